// File: rtl/idli_pkg.sv
// Shared types for the idli core: nibble slices, word-phase counter, words and
// the memory-controller sequencing states.
package idli_pkg;

    typedef logic [3:0]  slice_t;
    typedef logic [1:0]  ctr_t;
    typedef logic [15:0] word_t;
    typedef logic [15:0] addr_t;

    typedef enum logic [1:0] {
        StRedirFe,
        StStream,
        StRedirLs,
        StLsXfer
    } mctl_state_e;

    // Nibble ctr of a word, LSB nibble at ctr 0.
    function automatic slice_t nibble(word_t w, ctr_t c);
        return w[{c, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/idli_mem_ctl_m_if.sv
// Core/SQI-facing bus of the memory controller. sqi_wdata feeds the SQI data
// input; sqi_rdata/sqi_rvld come back from the SQI data output.
interface idli_mem_ctl_m_if;
    import idli_pkg::*;

    ctr_t   ctr;
    logic   fe_redirect;
    addr_t  fe_addr;
    slice_t fe_data;
    logic   fe_vld;
    logic   ls_req;
    logic   ls_wr;
    addr_t  ls_addr;
    word_t  ls_wdata;
    logic   ls_ack;
    word_t  ls_rdata;
    logic   sqi_redirect;
    logic   sqi_wr_en;
    slice_t sqi_wdata;
    slice_t sqi_rdata;
    logic   sqi_rvld;

    modport slave (
        input  fe_redirect, fe_addr, ls_req, ls_wr, ls_addr, ls_wdata, sqi_rdata, sqi_rvld,
        output ctr, fe_data, fe_vld, ls_ack, ls_rdata, sqi_redirect, sqi_wr_en, sqi_wdata
    );

    modport master (
        output fe_redirect, fe_addr, ls_req, ls_wr, ls_addr, ls_wdata, sqi_rdata, sqi_rvld,
        input  ctr, fe_data, fe_vld, ls_ack, ls_rdata, sqi_redirect, sqi_wr_en, sqi_wdata
    );

endinterface

// File: rtl/idli_mctl_ser_m.sv
// Nibble serialiser (parallel load, shift out LSB first) and ctr-indexed
// deserialiser whose result is committed to the load-data register.
module idli_mctl_ser_m
    import idli_pkg::*;
(
    input  logic   i_ser_gck,
    input  logic   i_ser_rst,
    input  logic   i_ser_ld,
    input  word_t  i_ser_ld_word,
    output slice_t o_ser_nib,
    input  logic   i_ser_cap,
    input  ctr_t   i_ser_cap_idx,
    input  slice_t i_ser_cap_nib,
    input  logic   i_ser_commit,
    output word_t  o_ser_rdata
);

    word_t sr_q, sr_d;
    word_t cap_q, cap_d;
    word_t rdata_q, rdata_d;

    always_comb begin
        sr_d    = i_ser_ld ? i_ser_ld_word : {4'h0, sr_q[15:4]};
        cap_d   = cap_q;
        if (i_ser_cap) begin
            cap_d[{i_ser_cap_idx, 2'b00} +: 4] = i_ser_cap_nib;
        end
        // Commit includes the nibble captured in the same cycle.
        rdata_d = i_ser_commit ? cap_d : rdata_q;
    end

    always_ff @(posedge i_ser_gck) begin
        if (i_ser_rst) begin
            sr_q    <= '0;
            cap_q   <= '0;
            rdata_q <= '0;
        end else begin
            sr_q    <= sr_d;
            cap_q   <= cap_d;
            rdata_q <= rdata_d;
        end
    end

    assign o_ser_nib   = sr_q[3:0];
    assign o_ser_rdata = rdata_q;

endmodule

// File: rtl/idli_mem_ctl_m.sv
// Memory controller: owns the word-phase counter and shares the SQI port between
// instruction fetch streaming and a single load/store requester.
module idli_mem_ctl_m
    import idli_pkg::*;
(
    input  logic            i_mctl_gck,
    input  logic            i_mctl_rst,
    idli_mem_ctl_m_if.slave mctl
);

    ctr_t        ctr_q;
    mctl_state_e state_q, state_d;
    addr_t       fe_pc_q, fe_pc_d;
    logic        pend_q, pend_d;
    logic        ack_q, ack_d;
    logic        boundary;
    logic        fe_vld;
    logic        ser_ld, ser_cap, ser_commit;
    word_t       ser_ld_word, ser_rdata;
    slice_t      ser_nib;

    assign boundary = (ctr_q == 2'd3);
    // A pending redirect makes the streamed nibbles stale.
    assign fe_vld   = (state_q == StStream) && mctl.sqi_rvld && !pend_q;

    always_comb begin
        state_d = state_q;
        if (boundary) begin
            unique case (state_q)
                StRedirFe: state_d = StStream;
                StStream: begin
                    if (mctl.ls_req) begin
                        state_d = StRedirLs;
                    end else if (pend_q || mctl.fe_redirect) begin
                        state_d = StRedirFe;
                    end
                end
                StRedirLs: state_d = StLsXfer;
                StLsXfer: begin
                    if (mctl.ls_wr || mctl.sqi_rvld) begin
                        state_d = StRedirFe;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        fe_pc_d = fe_pc_q;
        pend_d  = pend_q;
        if (mctl.fe_redirect) begin
            fe_pc_d = mctl.fe_addr;
            pend_d  = 1'b1;
        end else if (boundary && fe_vld) begin
            fe_pc_d = fe_pc_q + 16'd1;
        end
        if (boundary && (state_q != StRedirFe) && (state_d == StRedirFe)) begin
            pend_d = 1'b0;
        end
    end

    assign ack_d       = boundary && (state_q == StLsXfer) && (state_d == StRedirFe);
    assign ser_ld      = boundary && (state_q != state_d) &&
                         ((state_d == StRedirLs) || (state_d == StLsXfer));
    assign ser_ld_word = (state_d == StLsXfer) ? mctl.ls_wdata : mctl.ls_addr;
    assign ser_cap     = (state_q == StLsXfer) && !mctl.ls_wr && mctl.sqi_rvld;
    assign ser_commit  = ack_d && !mctl.ls_wr;

    always_ff @(posedge i_mctl_gck) begin
        if (i_mctl_rst) begin
            ctr_q   <= '0;
            state_q <= StRedirFe;
            fe_pc_q <= '0;
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            ctr_q   <= ctr_q + 2'd1;
            state_q <= state_d;
            fe_pc_q <= fe_pc_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
        end
    end

    idli_mctl_ser_m u_ser (
        .i_ser_gck     (i_mctl_gck),
        .i_ser_rst     (i_mctl_rst),
        .i_ser_ld      (ser_ld),
        .i_ser_ld_word (ser_ld_word),
        .o_ser_nib     (ser_nib),
        .i_ser_cap     (ser_cap),
        .i_ser_cap_idx (ctr_q),
        .i_ser_cap_nib (mctl.sqi_rdata),
        .i_ser_commit  (ser_commit),
        .o_ser_rdata   (ser_rdata)
    );

    // Outputs are forced low for as long as reset is held.
    always_comb begin
        mctl.ctr          = '0;
        mctl.fe_data      = '0;
        mctl.fe_vld       = 1'b0;
        mctl.ls_ack       = 1'b0;
        mctl.ls_rdata     = '0;
        mctl.sqi_redirect = 1'b0;
        mctl.sqi_wr_en    = 1'b0;
        mctl.sqi_wdata    = '0;
        if (!i_mctl_rst) begin
            mctl.ctr      = ctr_q;
            mctl.ls_ack   = ack_q;
            mctl.ls_rdata = ser_rdata;
            unique case (state_q)
                StRedirFe: begin
                    mctl.sqi_redirect = 1'b1;
                    mctl.sqi_wdata    = nibble(fe_pc_q, ctr_q);
                end
                StStream: begin
                    mctl.fe_data = mctl.sqi_rdata;
                    mctl.fe_vld  = fe_vld;
                end
                StRedirLs: begin
                    mctl.sqi_redirect = 1'b1;
                    mctl.sqi_wr_en    = mctl.ls_wr;
                    mctl.sqi_wdata    = ser_nib;
                end
                StLsXfer: begin
                    if (mctl.ls_wr) begin
                        mctl.sqi_wr_en = 1'b1;
                        mctl.sqi_wdata = ser_nib;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_idli_mem_ctl_m.sv
// Bench for idli_mem_ctl_m: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a word-level model.
module tb_idli_mem_ctl_m;

    localparam int KFA = 0;  // fetch address word
    localparam int KST = 1;  // fetch stream word
    localparam int KLA = 2;  // load/store address word
    localparam int KLX = 3;  // load/store data word

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    idli_mem_ctl_m_if mctl();

    idli_mem_ctl_m dut (
        .i_mctl_gck (clk),
        .i_mctl_rst (rst),
        .mctl       (mctl)
    );

    always #5 clk = ~clk;

    // Word-level model state.
    int          m_phase = 0;
    int          m_kind  = KFA;
    logic [15:0] m_pc    = '0;
    logic [15:0] m_buf   = '0;
    logic [15:0] m_rdata = '0;
    logic        m_pend  = 1'b0;
    logic        m_ack   = 1'b0;
    logic        prev_ack  = 1'b0;
    logic        prev_rvld = 1'b0;

    logic        e_redir, e_wr, e_fev, n_ack, bnd;
    logic [3:0]  e_tx;
    int          n_kind;

    function automatic logic [3:0] nib(input logic [15:0] w, input int p);
        logic [15:0] t;
        t = w >> (4 * p);
        return t[3:0];
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            check("rst_ctr", 32'(mctl.ctr), 0);
            check("rst_redirect", 32'(mctl.sqi_redirect), 0);
            check("rst_wr_en", 32'(mctl.sqi_wr_en), 0);
            check("rst_fe_vld", 32'(mctl.fe_vld), 0);
            check("rst_ack", 32'(mctl.ls_ack), 0);
            check("rst_rdata", 32'(mctl.ls_rdata), 0);
            m_phase = 0; m_kind = KFA; m_pc = '0; m_pend = 1'b0;
            m_ack = 1'b0; m_rdata = '0; prev_ack = 1'b0;
        end else begin
            e_redir = 1'b0; e_wr = 1'b0; e_tx = '0; e_fev = 1'b0;
            case (m_kind)
                KFA: begin e_redir = 1'b1; e_tx = nib(m_pc, m_phase); end
                KST: e_fev = mctl.sqi_rvld && !m_pend;
                KLA: begin
                    e_redir = 1'b1; e_wr = mctl.ls_wr; e_tx = nib(mctl.ls_addr, m_phase);
                end
                default: begin
                    e_wr = mctl.ls_wr;
                    if (mctl.ls_wr) e_tx = nib(mctl.ls_wdata, m_phase);
                end
            endcase
            check("m_ctr", 32'(mctl.ctr), 32'(m_phase));
            check("m_redirect", 32'(mctl.sqi_redirect), 32'(e_redir));
            check("m_wr_en", 32'(mctl.sqi_wr_en), 32'(e_wr));
            if (e_redir || e_wr) check("m_sqi_data", 32'(mctl.sqi_wdata), 32'(e_tx));
            check("m_fe_vld", 32'(mctl.fe_vld), 32'(e_fev));
            if (e_fev) check("m_fe_data", 32'(mctl.fe_data), 32'(mctl.sqi_rdata));
            check("m_ack", 32'(mctl.ls_ack), 32'(m_ack));
            check("m_rdata", 32'(mctl.ls_rdata), 32'(m_rdata));
            prev_ack = m_ack;

            bnd    = (m_phase == 3);
            n_kind = m_kind;
            if (bnd) begin
                case (m_kind)
                    KFA: n_kind = KST;
                    KST: if (mctl.ls_req) n_kind = KLA;
                         else if (m_pend || mctl.fe_redirect) n_kind = KFA;
                    KLA: n_kind = KLX;
                    default: if (mctl.ls_wr || mctl.sqi_rvld) n_kind = KFA;
                endcase
            end
            if (m_kind == KLX && !mctl.ls_wr && mctl.sqi_rvld)
                m_buf[m_phase*4 +: 4] = mctl.sqi_rdata;
            n_ack = bnd && (m_kind == KLX) && (n_kind == KFA);
            if (n_ack && !mctl.ls_wr) m_rdata = m_buf;
            if (mctl.fe_redirect) begin
                m_pc = mctl.fe_addr; m_pend = 1'b1;
            end else if (bnd && e_fev) begin
                m_pc = m_pc + 16'd1;
            end
            if (n_kind == KFA && m_kind != KFA) m_pend = 1'b0;
            m_ack   = n_ack;
            m_kind  = n_kind;
            m_phase = (m_phase + 1) % 4;
        end
        // SQI data words must start on ctr 0.
        if (mctl.sqi_rvld && !prev_rvld) check("vld_align_ctr", 32'(mctl.ctr), 0);
        prev_rvld = mctl.sqi_rvld;
    end

    task automatic probe_zero(input string nm);
        check({nm, "_ctr"}, 32'(mctl.ctr), 0);
        check({nm, "_redirect"}, 32'(mctl.sqi_redirect), 0);
        check({nm, "_wr_en"}, 32'(mctl.sqi_wr_en), 0);
        check({nm, "_sqi_data"}, 32'(mctl.sqi_wdata), 0);
        check({nm, "_fe_vld"}, 32'(mctl.fe_vld), 0);
        check({nm, "_ack"}, 32'(mctl.ls_ack), 0);
        check({nm, "_rdata"}, 32'(mctl.ls_rdata), 0);
    endtask

    // One SQI word (4 cycles) starting at ctr 0, with literal expectations.
    task automatic run_word(input string nm, input logic vld, input logic [15:0] rx,
                            input logic x_redir, input logic x_wr, input logic [15:0] x_tx,
                            input logic [3:0] x_fev, input logic x_ack,
                            input int redir_k, input logic [15:0] redir_addr);
        for (int k = 0; k < 4; k++) begin
            mctl.sqi_rvld    = vld;
            mctl.sqi_rdata   = nib(rx, k);
            mctl.fe_redirect = (k == redir_k);
            if (k == redir_k) mctl.fe_addr = redir_addr;
            #3;
            check({nm, "_ctr"}, 32'(mctl.ctr), 32'(k));
            check({nm, "_redirect"}, 32'(mctl.sqi_redirect), 32'(x_redir));
            check({nm, "_wr_en"}, 32'(mctl.sqi_wr_en), 32'(x_wr));
            if (x_redir || x_wr) check({nm, "_sqi_data"}, 32'(mctl.sqi_wdata), 32'(nib(x_tx, k)));
            check({nm, "_fe_vld"}, 32'(mctl.fe_vld), 32'(x_fev[k]));
            if (x_fev[k]) check({nm, "_fe_data"}, 32'(mctl.fe_data), 32'(nib(rx, k)));
            check({nm, "_ack"}, 32'(mctl.ls_ack), (k == 0) ? 32'(x_ack) : 0);
            @(posedge clk); #1;
        end
        mctl.fe_redirect = 1'b0;
        mctl.sqi_rvld    = 1'b0;
    endtask

    task automatic set_ls(input logic req, input logic wr, input logic [15:0] a,
                          input logic [15:0] d);
        mctl.ls_req = req; mctl.ls_wr = wr; mctl.ls_addr = a; mctl.ls_wdata = d;
    endtask

    logic word_vld;

    initial begin
        rst = 1'b1;
        mctl.fe_redirect = 1'b0; mctl.fe_addr = '0;
        mctl.sqi_rdata = '0; mctl.sqi_rvld = 1'b0;
        set_ls(1'b0, 1'b0, 16'h0, 16'h0);
        repeat (3) @(posedge clk);
        #1; #3;
        probe_zero("reset_hold");
        @(posedge clk); #1;
        rst = 1'b0;

        run_word("rst_redir", 0, 16'h0, 1, 0, 16'h0000, 4'h0, 0, -1, 16'h0);
        run_word("fetch_a5c3", 1, 16'hA5C3, 0, 0, 16'h0, 4'hF, 0, -1, 16'h0);
        check("model_pc_first", 32'(m_pc), 32'h0001);
        for (int i = 0; i < 3; i++)
            run_word("stream", 1, 16'($urandom), 0, 0, 16'h0, 4'hF, 0, -1, 16'h0);
        set_ls(1'b1, 1'b0, 16'h0100, 16'h0);
        run_word("stream_req", 1, 16'($urandom), 0, 0, 16'h0, 4'hF, 0, -1, 16'h0);
        run_word("ld_addr", 0, 16'h0, 1, 0, 16'h0100, 4'h0, 0, -1, 16'h0);
        run_word("ld_xfer", 1, 16'hBEEF, 0, 0, 16'h0, 4'h0, 0, -1, 16'h0);
        run_word("ld_resume", 0, 16'h0, 1, 0, 16'h0005, 4'h0, 1, -1, 16'h0);
        set_ls(1'b0, 1'b0, 16'h0, 16'h0);
        check("ld_rdata", 32'(mctl.ls_rdata), 32'hBEEF);

        run_word("fe_redir", 1, 16'h1111, 0, 0, 16'h0, 4'b0011, 0, 1, 16'h1234);
        run_word("redir_1234", 0, 16'h0, 1, 0, 16'h1234, 4'h0, 0, -1, 16'h0);
        check("model_pc_1234", 32'(m_pc), 32'h1234);

        set_ls(1'b1, 1'b1, 16'h0200, 16'hCAFE);
        run_word("st_stream", 0, 16'h0, 0, 0, 16'h0, 4'h0, 0, -1, 16'h0);
        run_word("st_addr", 0, 16'h0, 1, 1, 16'h0200, 4'h0, 0, -1, 16'h0);
        run_word("st_data", 0, 16'h0, 0, 1, 16'hCAFE, 4'h0, 0, -1, 16'h0);
        run_word("st_resume", 0, 16'h0, 1, 0, 16'h1234, 4'h0, 1, -1, 16'h0);
        set_ls(1'b0, 1'b0, 16'h0, 16'h0);
        check("st_rdata_kept", 32'(mctl.ls_rdata), 32'hBEEF);

        set_ls(1'b1, 1'b0, 16'h0300, 16'h0);
        run_word("col_stream", 0, 16'h0, 0, 0, 16'h0, 4'h0, 0, 3, 16'h0040);
        run_word("col_addr", 0, 16'h0, 1, 0, 16'h0300, 4'h0, 0, -1, 16'h0);
        run_word("col_xfer", 1, 16'h1357, 0, 0, 16'h0, 4'h0, 0, -1, 16'h0);
        run_word("col_resume", 0, 16'h0, 1, 0, 16'h0040, 4'h0, 1, -1, 16'h0);
        set_ls(1'b0, 1'b0, 16'h0, 16'h0);
        check("col_rdata", 32'(mctl.ls_rdata), 32'h1357);

        run_word("wrap_setpc", 0, 16'h0, 0, 0, 16'h0, 4'h0, 0, 0, 16'hFFFF);
        run_word("wrap_redir", 0, 16'h0, 1, 0, 16'hFFFF, 4'h0, 0, -1, 16'h0);
        run_word("wrap_word", 1, 16'($urandom), 0, 0, 16'h0, 4'hF, 0, -1, 16'h0);
        check("model_pc_wrap", 32'(m_pc), 32'h0000);
        set_ls(1'b1, 1'b0, 16'h0500, 16'h0);
        run_word("wrap_req", 0, 16'h0, 0, 0, 16'h0, 4'h0, 0, -1, 16'h0);
        run_word("wrap_addr", 0, 16'h0, 1, 0, 16'h0500, 4'h0, 0, -1, 16'h0);
        run_word("wrap_xfer", 1, 16'h2468, 0, 0, 16'h0, 4'h0, 0, -1, 16'h0);
        run_word("wrap_resume", 0, 16'h0, 1, 0, 16'h0000, 4'h0, 1, -1, 16'h0);
        set_ls(1'b0, 1'b0, 16'h0, 16'h0);

        set_ls(1'b1, 1'b0, 16'h0400, 16'h0);
        run_word("ab_stream", 0, 16'h0, 0, 0, 16'h0, 4'h0, 0, -1, 16'h0);
        run_word("ab_addr", 0, 16'h0, 1, 0, 16'h0400, 4'h0, 0, -1, 16'h0);
        mctl.sqi_rvld = 1'b1; mctl.sqi_rdata = 4'h9;
        @(posedge clk); #1;
        rst = 1'b1; mctl.sqi_rvld = 1'b0;
        #3;
        probe_zero("abort");
        @(posedge clk); #1;
        set_ls(1'b0, 1'b0, 16'h0, 16'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_word("ab_resume", 0, 16'h0, 1, 0, 16'h0000, 4'h0, 0, -1, 16'h0);
        check("ab_rdata", 32'(mctl.ls_rdata), 0);

        word_vld = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (m_phase == 0) word_vld = ($urandom_range(0, 3) != 0);
            mctl.sqi_rvld    = word_vld;
            mctl.sqi_rdata   = 4'($urandom_range(0, 15));
            mctl.fe_redirect = ($urandom_range(0, 31) == 0);
            mctl.fe_addr     = 16'($urandom);
            if (mctl.ls_req && prev_ack) begin
                mctl.ls_req = 1'b0;
            end else if (!mctl.ls_req && $urandom_range(0, 11) == 0) begin
                set_ls(1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
            end
            rst = ($urandom_range(0, 599) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
